fdc_sd_arbiter: RTL and testbench

Shares one MiSTer SD block channel among the four per-drive WD1793 instances in the floppy subsystem. Serialises their sector read/write requests with round-robin arbitration, latches the granted drive's LBA, and drives the host-side request lines. Routes the host acknowledge and buffer write strobe back to the granted drive only, and muxes that drive's buffer output to the host. It sits between the four WD1793 `sd_*` ports and the single-channel HPS block interface.

---
 rtl/fdc_pkg.sv | 20 ++
 rtl/fdc_rr_pick.sv | 23 ++
 rtl/fdc_sd_arbiter.sv | 117 +++++++++++
 tb/tb_fdc_sd_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fdc_pkg.sv
// Shared types for the floppy-side SD arbitration logic.
package fdc_pkg;

  localparam int NUM_DRV = 4;

  typedef logic [1:0] drv_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } fdc_arb_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } fdc_op_t;

endpackage

// File: rtl/fdc_rr_pick.sv
// Round-robin picker: first pending requester strictly after `last`, modulo 4.
module fdc_rr_pick
  import fdc_pkg::*;
(
  input  logic [NUM_DRV-1:0] req,
  input  drv_idx_t           last,
  output logic               valid,
  output drv_idx_t           idx
);

  // Walk from farthest to nearest so the nearest pending drive wins.
  always_comb begin
    valid = 1'b0;
    idx   = last;
    for (int k = NUM_DRV; k >= 1; k--) begin
      if (req[drv_idx_t'(last + drv_idx_t'(k))]) begin
        valid = 1'b1;
        idx   = drv_idx_t'(last + drv_idx_t'(k));
      end
    end
  end

endmodule

// File: rtl/fdc_sd_arbiter.sv
// Shares one SD block channel among four WD1793 drives with round-robin grants.
// Define FDC_ARB_TIMEOUT_EN to build in the watchdog and the REQ_ERR port.
//
//   state   | meaning
//   IDLE    | no grant, searching for the next pending drive
//   ISSUE   | host request raised, waiting for HOST_ACK
//   XFER    | host acked, data moves to/from granted drive
//   RELEASE | waiting for the granted drive to drop its request
module fdc_sd_arbiter #(
  parameter int NUM_DRV = 4
`ifdef FDC_ARB_TIMEOUT_EN
  , parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
`endif
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [31:0]        REQ_LBA [NUM_DRV],
  input  logic [NUM_DRV-1:0] REQ_RD,
  input  logic [NUM_DRV-1:0] REQ_WR,
  output logic [NUM_DRV-1:0] REQ_ACK,
  output logic [NUM_DRV-1:0] REQ_BUFF_WR,
  input  logic [7:0]         REQ_BUFF_DIN [NUM_DRV],
`ifdef FDC_ARB_TIMEOUT_EN
  output logic [NUM_DRV-1:0] REQ_ERR,
`endif
  output logic [31:0]        HOST_LBA,
  output logic               HOST_RD,
  output logic               HOST_WR,
  input  logic               HOST_ACK,
  input  logic               HOST_BUFF_WR,
  output logic [7:0]         HOST_BUFF_DIN,
  output logic               BUSY,
  output logic [1:0]         GRANT_IDX
);

  import fdc_pkg::*;

  fdc_arb_state_t     state;
  fdc_arb_state_t     state_nxt;
  fdc_op_t            op;
  logic [NUM_DRV-1:0] pend;
  logic [NUM_DRV-1:0] grant_oh;
  logic               pick_valid;
  drv_idx_t           pick_idx;
  logic               timeout;

  assign pend     = REQ_RD | REQ_WR;
  assign grant_oh = {{(NUM_DRV-1){1'b0}}, 1'b1} << GRANT_IDX;

  fdc_rr_pick u_pick (
    .req   (pend),
    .last  (GRANT_IDX),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

`ifdef FDC_ARB_TIMEOUT_EN
  logic [23:0] wd_cnt;

  always_ff @(posedge CLK) begin
    if (RESET || state_nxt != state)
      wd_cnt <= '0;
    else if (state == ISSUE || state == XFER)
      wd_cnt <= wd_cnt + 24'd1;
  end

  assign timeout = (state == ISSUE || state == XFER) && (wd_cnt == TIMEOUT_CYCLES - 24'd1);

  always_ff @(posedge CLK) begin
    if (RESET)
      REQ_ERR <= '0;
    else
      REQ_ERR <= timeout ? grant_oh : '0;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_valid) state_nxt = ISSUE;
      ISSUE:   if (timeout || HOST_ACK) state_nxt = timeout ? RELEASE : XFER;
      XFER:    if (timeout || !HOST_ACK) state_nxt = RELEASE;
      RELEASE: if (!pend[GRANT_IDX]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Host and drive handshake lines follow the state one cycle late.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      op        <= OP_RD;
      GRANT_IDX <= 2'd3;
      HOST_LBA  <= '0;
      HOST_RD   <= 1'b0;
      HOST_WR   <= 1'b0;
      REQ_ACK   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_valid) begin
        HOST_LBA  <= REQ_LBA[pick_idx];
        GRANT_IDX <= pick_idx;
        op        <= REQ_RD[pick_idx] ? OP_RD : OP_WR;
      end
      HOST_RD <= (state == ISSUE) && !timeout && (op == OP_RD);
      HOST_WR <= (state == ISSUE) && !timeout && (op == OP_WR);
      REQ_ACK <= (state == XFER && !timeout) ? grant_oh : '0;
    end
  end

  assign REQ_BUFF_WR   = (state == XFER && HOST_BUFF_WR) ? grant_oh : '0;
  assign HOST_BUFF_DIN = REQ_BUFF_DIN[GRANT_IDX];
  assign BUSY          = (state != IDLE);

endmodule

// File: tb/tb_fdc_sd_arbiter.sv
// Directed bench for fdc_sd_arbiter with hand-computed expectations.
module tb_fdc_sd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_lba [4];
  logic [3:0]  req_rd;
  logic [3:0]  req_wr;
  logic [3:0]  req_ack;
  logic [3:0]  req_buff_wr;
  logic [7:0]  req_buff_din [4];
`ifdef FDC_ARB_TIMEOUT_EN
  logic [3:0]  req_err;
`endif
  logic [31:0] host_lba;
  logic        host_rd;
  logic        host_wr;
  logic        host_ack;
  logic        host_buff_wr;
  logic [7:0]  host_buff_din;
  logic        busy;
  logic [1:0]  grant_idx;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fdc_sd_arbiter #(
    .NUM_DRV        (4)
`ifdef FDC_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES (24'd100)
`endif
  ) dut (
    .CLK           (clk),
    .RESET         (rst),
    .REQ_LBA       (req_lba),
    .REQ_RD        (req_rd),
    .REQ_WR        (req_wr),
    .REQ_ACK       (req_ack),
    .REQ_BUFF_WR   (req_buff_wr),
    .REQ_BUFF_DIN  (req_buff_din),
`ifdef FDC_ARB_TIMEOUT_EN
    .REQ_ERR       (req_err),
`endif
    .HOST_LBA      (host_lba),
    .HOST_RD       (host_rd),
    .HOST_WR       (host_wr),
    .HOST_ACK      (host_ack),
    .HOST_BUFF_WR  (host_buff_wr),
    .HOST_BUFF_DIN (host_buff_din),
    .BUSY          (busy),
    .GRANT_IDX     (grant_idx)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction for drive i, starting in IDLE with its request pending.
  task automatic serve(input int i, input logic exp_rd, input logic exp_wr, input int nbytes);
    logic [31:0] oh;
    int hits;
    int stray;
    oh    = 32'(1) << i;
    hits  = 0;
    stray = 0;
    chk("idle_before_grant", 32'(busy), 32'd0);
    tick();
    chk("grant_idx", 32'(grant_idx), 32'(i));
    chk("host_lba", host_lba, req_lba[i]);
    chk("rd_not_yet", 32'(host_rd | host_wr), 32'd0);
    chk("host_buff_din", 32'(host_buff_din), 32'(8'hA0) + 32'(i));
    tick();
    chk("host_rd", 32'(host_rd), 32'(exp_rd));
    chk("host_wr", 32'(host_wr), 32'(exp_wr));
    host_ack = 1'b1;
    tick();
    chk("ack_lag", 32'(req_ack), 32'd0);
    tick();
    chk("req_ack", 32'(req_ack), oh);
    chk("req_dropped", 32'(host_rd | host_wr), 32'd0);
    for (int b = 0; b < nbytes; b++) begin
      host_buff_wr = 1'b1;
      #1;
      if (32'(req_buff_wr) == oh) hits++;
      if ((32'(req_buff_wr) & ~oh) != 32'd0) stray++;
      host_buff_wr = 1'b0;
      #1;
      if (req_buff_wr != 4'd0) stray++;
      tick();
    end
    chk("buff_wr_hits", 32'(hits), 32'(nbytes));
    chk("buff_wr_stray", 32'(stray), 32'd0);
    host_ack = 1'b0;
    tick();
    chk("ack_hold", 32'(req_ack), oh);
    tick();
    chk("ack_released", 32'(req_ack), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    req_rd       = 4'd0;
    req_wr       = 4'd0;
    host_ack     = 1'b0;
    host_buff_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_lba[i]      = 32'h1000_0000 + 32'(i) * 32'h111;
      req_buff_din[i] = 8'hA0 + 8'(i);
    end
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_host_rd", 32'(host_rd), 32'd0);
    chk("rst_host_wr", 32'(host_wr), 32'd0);
    chk("rst_req_ack", 32'(req_ack), 32'd0);
    chk("rst_grant", 32'(grant_idx), 32'd3);
    chk("rst_lba", host_lba, 32'd0);

    // Single read on drive 2 with a 256-byte buffer fill.
    rst        = 1'b0;
    req_lba[2] = 32'h12;
    req_rd     = 4'b0100;
    serve(2, 1'b1, 1'b0, 256);
    chk("release_holds", 32'(busy), 32'd1);
    host_buff_wr = 1'b1;
    #1;
    chk("no_strobe_release", 32'(req_buff_wr), 32'd0);
    host_buff_wr = 1'b0;
    req_rd = 4'd0;
    tick();
    chk("read_done_idle", 32'(busy), 32'd0);

    // All four writes pending from reset: order 0,1,2,3 twice.
    rst    = 1'b1;
    req_wr = 4'hF;
    tick();
    chk("rr_rst_grant", 32'(grant_idx), 32'd3);
    rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        serve(i, 1'b0, 1'b1, 2);
        tick();
        chk("no_phantom", 32'(busy), 32'd1);
        req_wr[i] = 1'b0;
        tick();
        if (r == 0) req_wr[i] = 1'b1;
      end
    end

    // Drive 1 raises read and write together: read wins.
    req_rd[1] = 1'b1;
    req_wr[1] = 1'b1;
    serve(1, 1'b1, 1'b0, 0);
    req_rd = 4'd0;
    req_wr = 4'd0;
    tick();
    chk("prio_idle", 32'(busy), 32'd0);

    // Drive 0 withdraws while in ISSUE; the transaction still completes.
    req_rd = 4'b0001;
    tick();
    chk("wd_grant", 32'(grant_idx), 32'd0);
    req_rd = 4'd0;
    tick();
    chk("wd_rd_up", 32'(host_rd), 32'd1);
    tick();
    chk("wd_rd_held", 32'(host_rd), 32'd1);
    chk("wd_busy", 32'(busy), 32'd1);
    host_ack = 1'b1;
    tick();
    tick();
    chk("wd_ack", 32'(req_ack), 32'd1);
    host_ack = 1'b0;
    tick();
    tick();
    chk("wd_idle", 32'(busy), 32'd0);
    chk("wd_ack_low", 32'(req_ack), 32'd0);

`ifdef FDC_ARB_TIMEOUT_EN
    // Host never acks drive 3: watchdog fires on the 100th ISSUE cycle.
    req_rd = 4'b1000;
    tick();
    chk("to_grant", 32'(grant_idx), 32'd3);
    repeat (99) tick();
    chk("to_rd_before", 32'(host_rd), 32'd1);
    chk("to_err_before", 32'(req_err), 32'd0);
    tick();
    chk("to_rd_dropped", 32'(host_rd), 32'd0);
    chk("to_err_pulse", 32'(req_err), 32'h8);
    tick();
    chk("to_err_cleared", 32'(req_err), 32'd0);
    req_rd = 4'd0;
    tick();
    chk("to_idle", 32'(busy), 32'd0);
`endif

    // Reset while drive 2 is mid-transfer.
    req_rd = 4'b0100;
    tick();
    tick();
    host_ack = 1'b1;
    tick();
    tick();
    chk("pre_rst_ack", 32'(req_ack), 32'h4);
    rst = 1'b1;
    tick();
    chk("mid_rst_rd", 32'(host_rd), 32'd0);
    chk("mid_rst_wr", 32'(host_wr), 32'd0);
    chk("mid_rst_ack", 32'(req_ack), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_grant", 32'(grant_idx), 32'd3);
    rst      = 1'b0;
    host_ack = 1'b0;
    req_rd   = 4'd0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
